// File: rtl/tty_uart_tx.sv
// TTY-port UART transmitter: FIFO-buffered 7-bit characters sent as 8N1 frames on tx_o.
// Define TTY_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module tty_uart_tx #(
    parameter int CLK_DIV         = 104,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic [6:0] tty_i,
    input  logic       tty_we_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       fifo_full_o,
    output logic       overflow_o,
    output logic [2:0] state_o
);

    localparam int                     DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int                     CW      = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]          DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]          CNT_ONE = CW'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);
    localparam logic [15:0]            DIV_M1  = 16'(CLK_DIV - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef TTY_UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [6:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [CW-1:0]              count_q, count_d;
    logic [2:0]                 state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [2:0]                 bit_q, bit_d;
    logic [7:0]                 shreg_q, shreg_d;
    logic                       tx_q, tx_d;
    logic                       busy_q, full_q, ovf_q;
    logic                       push, pop, tick;
`ifdef TTY_UART_PARITY_EN
    logic                       parity_q, parity_d;
`endif

    always_comb begin
        push    = tty_we_i && (count_q != DEPTH_C);
        pop     = 1'b0;
        tick    = (cnt_q == 16'd0);
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
`ifdef TTY_UART_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = {1'b0, mem[rptr_q]};
`ifdef TTY_UART_PARITY_EN
                    parity_d = ^mem[rptr_q];
`endif
                    cnt_d   = DIV_M1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    cnt_d   = DIV_M1;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = DIV_M1;
                    if (bit_q == 3'd7) begin
`ifdef TTY_UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef TTY_UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    cnt_d   = DIV_M1;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // Chain straight into the next start bit when more characters wait.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shreg_d = {1'b0, mem[rptr_q]};
`ifdef TTY_UART_PARITY_EN
                        parity_d = ^mem[rptr_q];
`endif
                        cnt_d   = DIV_M1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= tty_i;
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
            count_q <= count_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            // Busy spans exactly the frame window, plus any backlog already queued.
            busy_q  <= (state_d != IDLE) || (count_q != '0);
            full_q  <= (count_d == DEPTH_C);
            ovf_q   <= ovf_q || (tty_we_i && (count_q == DEPTH_C));
        end
    end

`ifdef TTY_UART_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) parity_q <= 1'b0;
        else         parity_q <= parity_d;
    end
`endif

    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign fifo_full_o = full_q;
    assign overflow_o  = ovf_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_tty_uart_tx.sv
// Directed bench for tty_uart_tx: a line monitor decodes frames into rx_q, compared in order with exp_q.
module tb_tty_uart_tx;

    localparam int CLK_DIV = 4;
`ifdef TTY_UART_PARITY_EN
    localparam int SLOTS     = 11;
    localparam int FRAME_CYC = 44;
`else
    localparam int SLOTS     = 10;
    localparam int FRAME_CYC = 40;
`endif

    logic       clk_i = 1'b0;
    logic       rst_in;
    logic [6:0] tty_i;
    logic       tty_we_i;
    logic       tx_o, busy_o, fifo_full_o, overflow_o;
    logic [2:0] state_o;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [6:0] exp_q[$];
    logic [6:0] rx_q[$];
    logic       rx_p[$];
    int         rx_t[$];

    tty_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH_LOG2(2)) dut (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .tty_i      (tty_i),
        .tty_we_i   (tty_we_i),
        .tx_o       (tx_o),
        .busy_o     (busy_o),
        .fifo_full_o(fifo_full_o),
        .overflow_o (overflow_o),
        .state_o    (state_o)
    );

    // Clock / cycle counter
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic write_char(input logic [6:0] ch);
        tty_i    = ch;
        tty_we_i = 1'b1;
        exp_q.push_back(ch);
        step(1);
        tty_we_i = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        chk({tag, "_timeout"}, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic drain_one(input string tag, output int t, output logic p);
        t = 0;
        p = 1'b0;
        chk({tag, "_have"}, 32'(rx_q.size() != 0 && exp_q.size() != 0), 32'd1);
        if (rx_q.size() != 0 && exp_q.size() != 0) begin
            chk({tag, "_data"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
            t = rx_t.pop_front();
            if (rx_p.size() != 0) p = rx_p.pop_front();
        end
    endtask

    // Line monitor: samples every cycle of every slot, aborts on reset
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_in === 1'b1 && tx_o === 1'b0) begin : capture
                logic [10:0] slot;
                logic        stable;
                logic        abort;
                int          t0;
                t0 = cyc;
                slot = '0;
                stable = 1'b1;
                abort = 1'b0;
                for (int s = 0; s < SLOTS; s++) begin
                    for (int c = 0; c < CLK_DIV; c++) begin
                        if (!(s == 0 && c == 0)) @(negedge clk_i);
                        if (rst_in !== 1'b1) begin
                            abort = 1'b1;
                            break;
                        end
                        if (c == 0) slot[s] = tx_o;
                        else if (tx_o !== slot[s]) stable = 1'b0;
                    end
                    if (abort) break;
                end
                if (!abort) begin
                    chk("frame_format", {28'd0, stable, slot[0], slot[8], slot[SLOTS-1]}, 32'b1001);
`ifdef TTY_UART_PARITY_EN
                    chk("frame_parity_even", 32'(slot[9]), 32'(^slot[8:1]));
                    rx_p.push_back(slot[9]);
`endif
                    rx_q.push_back(slot[7:1]);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   wcyc, t0, t1, n, k, i;
        logic p;

        // Reset values
        rst_in = 1'b1;
        tty_i = '0;
        tty_we_i = 1'b0;
        #3 rst_in = 1'b0;
        #1;
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_full", 32'(fifo_full_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        step(2);
        rst_in = 1'b1;
        step(2);

        // Single character 0x41: one-cycle latency, busy spans the frame exactly
        write_char(7'h41);
        wcyc = cyc;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_i);
            if (busy_o === 1'b1) n++;
        end
        chk("single_busy_cycles", 32'(n), 32'(FRAME_CYC));
        step(1);
        wait_rx("single", 1, 200);
        drain_one("single", t0, p);
        chk("single_latency", 32'(t0 - wcyc), 32'd1);
        chk("single_idle_tx", 32'(tx_o), 32'd1);
        chk("single_busy_end", 32'(busy_o), 32'd0);

        // Back-to-back 0x48, 0x69: second start bit follows the first stop bit
        step(3);
        write_char(7'h48);
        write_char(7'h69);
        wait_rx("b2b", 2, 300);
        drain_one("b2b0", t0, p);
        drain_one("b2b1", t1, p);
        chk("b2b_spacing", 32'(t1 - t0), 32'(FRAME_CYC));
        step(2);
        chk("b2b_ovf", 32'(overflow_o), 32'd0);
        chk("b2b_busy_end", 32'(busy_o), 32'd0);

        // Overflow: depth 4, six consecutive writes 0x31..0x36
        step(3);
        for (int w = 0; w < 6; w++) begin
            tty_i = 7'h31 + 7'(w);
            tty_we_i = 1'b1;
            if (w < 5) exp_q.push_back(7'h31 + 7'(w));
            step(1);
            if (w == 3) chk("ovf_full_after4", 32'(fifo_full_o), 32'd0);
            if (w == 4) chk("ovf_full_after5", 32'(fifo_full_o), 32'd1);
            if (w == 4) chk("ovf_clear_after5", 32'(overflow_o), 32'd0);
            if (w == 5) chk("ovf_set_after6", 32'(overflow_o), 32'd1);
        end
        tty_we_i = 1'b0;
        wait_rx("ovf", 5, 5 * FRAME_CYC + 100);
        for (int f = 0; f < 5; f++) drain_one("ovf_frame", t0, p);
        step(3 * FRAME_CYC);
        chk("ovf_no_sixth", 32'(rx_q.size()), 32'd0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        chk("ovf_full_drained", 32'(fifo_full_o), 32'd0);

        // Reset during bit 3 of 0x55 (that bit is 0 on the line)
        write_char(7'h55);
        step(18);
        rst_in = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_o), 32'd1);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_full", 32'(fifo_full_o), 32'd0);
        chk("midrst_ovf", 32'(overflow_o), 32'd0);
        void'(exp_q.pop_back());
        step(2);
        rst_in = 1'b1;
        step(3 * FRAME_CYC);
        chk("midrst_no_residual", 32'(rx_q.size()), 32'd0);
        chk("midrst_line_idle", 32'(tx_o), 32'd1);
        write_char(7'h41);
        wait_rx("midrst_new", 1, 200);
        drain_one("midrst_new", t0, p);

        // Wrap-around: 20 characters 0x40..0x53, written only while not full
        step(5);
        i = 0;
        k = 0;
        while (i < 20 && k < 5000) begin
            if (fifo_full_o === 1'b0) begin
                tty_i = 7'h40 + 7'(i);
                tty_we_i = 1'b1;
                exp_q.push_back(7'h40 + 7'(i));
                i++;
            end else begin
                tty_we_i = 1'b0;
            end
            step(1);
            k++;
        end
        tty_we_i = 1'b0;
        chk("wrap_all_written", 32'(i), 32'd20);
        wait_rx("wrap", 20, 25 * FRAME_CYC);
        for (int f = 0; f < 20; f++) drain_one("wrap_frame", t0, p);
        chk("wrap_ovf", 32'(overflow_o), 32'd0);

`ifdef TTY_UART_PARITY_EN
        // Even parity: 0x41 has two ones, 0x43 has three
        step(5);
        write_char(7'h41);
        wait_rx("par41", 1, 200);
        drain_one("par41", t0, p);
        chk("par41_bit", 32'(p), 32'd0);
        step(5);
        write_char(7'h43);
        wait_rx("par43", 1, 200);
        drain_one("par43", t0, p);
        chk("par43_bit", 32'(p), 32'd1);
`endif

        step(5);
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tty_uart_tx.md
Name: tty_uart_tx

Overview:
Serial transmitter at the consuming end of the MCU's TTY port. Accepts 7-bit characters written on the tty data/write-enable pair and buffers them in a small FIFO. Serialises each character as an 8N1 UART frame on a single output pin. Sits at the FPGA top level, beside the mcu instance, on the same clock.

Parameters:
CLK_DIV, 104, clock cycles per UART bit; legal range 2..65535.
FIFO_DEPTH_LOG2, 4, log2 of the FIFO depth in entries; legal range 1..8.

Ports:
clk_i  input  1  system clock; all state updates on the rising edge
rst_in  input  1  reset; asynchronous, active-low
tty_i  input  7  character from the mcu TTY port
tty_we_i  input  1  write strobe; one character per high cycle
tx_o  output  1  UART serial line, idle high
busy_o  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_full_o  output  1  FIFO holds 2^FIFO_DEPTH_LOG2 entries
overflow_o  output  1  sticky; a write was dropped because the FIFO was full

Behaviour:
- Reset (rst_in low, asynchronous):
  - tx_o=1, busy_o=0, fifo_full_o=0, overflow_o=0.
  - FIFO emptied; FSM to IDLE; baud counter and bit index cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high with no stop bit.
- FIFO:
  - Depth 2^FIFO_DEPTH_LOG2, 7 bits wide; registered read/write pointers and count.
  - A write with tty_we_i=1 and count<depth stores tty_i at that edge.
  - A write with tty_we_i=1 and count==depth is dropped and sets overflow_o at that edge. overflow_o stays set until reset.
  - The full test uses the registered count. A write while full is dropped even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop leaves count unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
  - IDLE: tx_o=1. If FIFO non-empty at an edge, pop the head into the shift register, load the baud counter with CLK_DIV-1, and enter START.
  - START: tx_o=0 for exactly CLK_DIV cycles.
  - DATA: 8 bits, LSB first. Bits 0..6 are the character; bit 7 is always 0. Each bit lasts exactly CLK_DIV cycles; bit index 0..7.
  - STOP: tx_o=1 for exactly CLK_DIV cycles. At its last cycle:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - Otherwise: go to IDLE.
- Baud counter: counts down from CLK_DIV-1. The state/bit advances on the edge where the counter is 0; the counter then reloads.
- tx_o is driven from a register (glitch-free).
- Latency: a write at edge E0 into an idle, empty block makes tx_o fall at edge E1. A frame is 10*CLK_DIV cycles (11*CLK_DIV with parity).
- busy_o = (state != IDLE) | (count != 0), registered. It deasserts after the stop bit of the last character.
- fifo_full_o = (count == depth), registered.
- tty_we_i high for N consecutive cycles writes N characters; no edge detection.

Optional Feature:
TTY_UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles. Frame becomes 8E1, 11*CLK_DIV cycles.
- Undefined: no PARITY state and no parity logic; frame is 8N1.

Test Plan:
- Single character: CLK_DIV=4, reset, write 0x41 once.
  - Required: tx_o=0 from the next edge, then 1,0,0,0,0,0,1,0, then stop 1, each bit held 4 cycles.
  - Required: busy_o=1 for 40 cycles, then 0.
- Back-to-back: write 0x48 and 0x69 on consecutive cycles.
  - Required: two frames totalling 80 cycles, with the second start bit immediately after the first stop bit.
  - Required: overflow_o=0.
- Overflow: FIFO_DEPTH_LOG2=2, CLK_DIV=4, write 0x31..0x36 on 6 consecutive cycles.
  - Required: fifo_full_o=1 after the 5th write; 6th write dropped; overflow_o=1 and sticky.
  - Required: exactly 5 frames (0x31..0x35) transmitted.
- Reset mid-frame: assert rst_in low during bit 3 of 0x55.
  - Required: tx_o=1, busy_o=0, fifo_full_o=0, overflow_o=0 asynchronously.
  - Required: after release, no residual frame; a new write of 0x41 is sent correctly.
- Wrap-around: FIFO_DEPTH_LOG2=2, stream 20 characters 0x40..0x53, writing only while fifo_full_o=0.
  - Required: all 20 received in order; overflow_o=0.
- Parity (TTY_UART_PARITY_EN defined):
  - 0x41: parity bit 0, frame 44 cycles at CLK_DIV=4.
  - 0x43: parity bit 1.
